// File: rtl/pulse_cmd_gen_pkg.sv
// Shared types and constants for the start/stop pulse command generator.
package pulse_cmd_pkg;

    // Default number of consecutive stable cycles needed to accept a level change.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    // Width of the per-button stability counter.
    localparam int unsigned CNT_W = 8;

    // Command FSM states.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_cmd_gen_if.sv
// Button inputs and command outputs of the pulse command generator.
interface pulse_cmd_if;
    logic start_btn;
    logic stop_btn;
    logic start;
    logic stop;
    logic running;

    // Drives the buttons and observes the commands.
    modport master (
        output start_btn,
        output stop_btn,
        input  start,
        input  stop,
        input  running
    );

    // The generator itself: consumes buttons, produces commands.
    modport slave (
        input  start_btn,
        input  stop_btn,
        output start,
        output stop,
        output running
    );
endinterface

// File: rtl/pulse_cmd_gen_btn_debounce.sv
// One button: 2-flop synchronizer, stability-counter debounce and a
// registered one-cycle rise event on the accepted level.
module btn_debounce
    import pulse_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    // Counter value on the last disagreeing cycle before the level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             rise_r;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Flag a low-to-high transition of the accepted level for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            level_d_r <= level_r;
            rise_r    <= level_r & ~level_d_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/pulse_cmd_gen.sv
// Turns debounced start/stop button presses into single-cycle start/stop
// commands for a downstream pulse counter, tracking whether it is running.
module pulse_cmd_gen
    import pulse_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    pulse_cmd_if.slave  bus
);

    logic   start_rise_s;
    logic   stop_rise_s;
    state_e state_r;
    state_e state_nx_s;
    logic   start_nx_s;
    logic   stop_nx_s;
    logic   start_r;
    logic   stop_r;
    logic   running_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.start_btn),
        .rise  (start_rise_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.stop_btn),
        .rise  (stop_rise_s)
    );

    // Next state and command pulses; a stop press always takes priority over start.
    always_comb begin
        state_nx_s = state_r;
        start_nx_s = 1'b0;
        stop_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s && !stop_rise_s) begin
                    start_nx_s = 1'b1;
                    state_nx_s = RUNNING;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUNNING: begin
                if (stop_rise_s) begin
                    stop_nx_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RUNNING;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; running tracks the next state so it
    // changes in the same cycle as the start/stop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            start_r   <= 1'b0;
            stop_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            start_r   <= start_nx_s;
            stop_r    <= stop_nx_s;
            running_r <= (state_nx_s == RUNNING);
        end
    end

    assign bus.start   = start_r;
    assign bus.stop    = stop_r;
    assign bus.running = running_r;

endmodule

// File: tb/tb_pulse_cmd_gen.sv
// Self-checking bench for pulse_cmd_gen with DEBOUNCE_CYCLES = 4.
module tb_pulse_cmd_gen;

    localparam int N = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pulse_cmd_if bus ();

    pulse_cmd_gen #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each button keeps its raw sample history; the level seen
    // by the debouncer at an edge is the sample from two edges earlier, and a new
    // level is accepted once the last N such samples all differ from the current
    // accepted level. A 0->1 acceptance reaches the command logic two edges later.
    bit hist  [2][0:N+1];
    bit acc   [2];
    bit rise1 [2];
    bit rise2 [2];
    bit m_run;
    bit exp_start;
    bit exp_stop;
    bit exp_running;

    task automatic model_step(input bit sb, input bit pb, input bit rs);
        bit smp [2];
        bit diff;
        smp[0] = sb;
        smp[1] = pb;
        if (rs) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i <= N + 1; i++) hist[b][i] = 1'b0;
                acc[b]   = 1'b0;
                rise1[b] = 1'b0;
                rise2[b] = 1'b0;
            end
            m_run       = 1'b0;
            exp_start   = 1'b0;
            exp_stop    = 1'b0;
            exp_running = 1'b0;
        end else begin
            exp_start = 1'b0;
            exp_stop  = 1'b0;
            if (rise2[1]) begin
                if (m_run) begin
                    exp_stop = 1'b1;
                    m_run    = 1'b0;
                end
            end else if (rise2[0] && !m_run) begin
                exp_start = 1'b1;
                m_run     = 1'b1;
            end
            exp_running = m_run;
            for (int b = 0; b < 2; b++) begin
                rise2[b] = rise1[b];
                for (int i = N + 1; i >= 1; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = smp[b];
                diff = 1'b1;
                for (int i = 2; i <= N + 1; i++) begin
                    if (hist[b][i] == acc[b]) diff = 1'b0;
                end
                rise1[b] = 1'b0;
                if (diff) begin
                    acc[b]   = hist[b][2];
                    rise1[b] = acc[b];
                end
            end
        end
    endtask

    // Apply inputs away from the active edge, clock once, advance the model.
    task automatic tick(input bit sb, input bit pb, input bit rs);
        @(negedge clk);
        bus.start_btn = sb;
        bus.stop_btn  = pb;
        reset         = rs;
        @(posedge clk);
        model_step(sb, pb, rs);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.start, bus.stop, bus.running} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state: got start/stop/running=%b required 000",
                     {bus.start, bus.stop, bus.running});
        end
    endtask

    // Start held 20 cycles: start only after edge N+3, then running.
    task automatic test_latency();
        test_reset();
        for (int e = 0; e < 20; e++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.start !== (e == N + 3) || bus.stop !== 1'b0 || bus.running !== (e >= N + 3)) begin
                failures++;
                $display("FAIL latency edge %0d: got start=%b stop=%b running=%b required %b 0 %b",
                         e, bus.start, bus.stop, bus.running, (e == N + 3), (e >= N + 3));
            end
            checks++;
            if ({bus.start, bus.stop, bus.running} !== {exp_start, exp_stop, exp_running}) begin
                failures++;
                $display("FAIL latency_model edge %0d: got %b required %b", e,
                         {bus.start, bus.stop, bus.running}, {exp_start, exp_stop, exp_running});
            end
        end
    endtask

    // A press shorter than the debounce window is ignored.
    task automatic test_short_press();
        int starts = 0;
        test_reset();
        for (int e = 0; e < 15; e++) begin
            tick((e < N - 1), 1'b0, 1'b0);
            starts += int'(bus.start);
            checks++;
            if (bus.start !== 1'b0 || bus.running !== 1'b0) begin
                failures++;
                $display("FAIL short_press edge %0d: got start=%b running=%b required 0 0",
                         e, bus.start, bus.running);
            end
        end
        checks++;
        if (starts != 0) begin
            failures++;
            $display("FAIL short_press_count: got %0d starts required 0", starts);
        end
    endtask

    // Phase-table driven scenario with per-cycle model comparison and pulse counts.
    task automatic run_phases(input string name, input bit sb_q[$], input bit pb_q[$],
                              input int len_q[$], output int starts, output int stops);
        starts = 0;
        stops  = 0;
        for (int p = 0; p < len_q.size(); p++) begin
            for (int c = 0; c < len_q[p]; c++) begin
                tick(sb_q[p], pb_q[p], 1'b0);
                starts += int'(bus.start);
                stops  += int'(bus.stop);
                checks++;
                if ({bus.start, bus.stop, bus.running} !== {exp_start, exp_stop, exp_running}) begin
                    failures++;
                    $display("FAIL %s phase %0d cycle %0d: got %b required %b", name, p, c,
                             {bus.start, bus.stop, bus.running}, {exp_start, exp_stop, exp_running});
                end
            end
        end
    endtask

    // Start press/release, then stop press: stop exactly N+3 edges after press.
    task automatic test_start_stop();
        int starts;
        int stops;
        int stop_edge = -1;
        test_reset();
        run_phases("start_then_release", '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{10, 10}, starts, stops);
        checks++;
        if (starts != 1 || stops != 0 || bus.running !== 1'b1) begin
            failures++;
            $display("FAIL start_phase: got starts=%0d stops=%0d running=%b required 1 0 1",
                     starts, stops, bus.running);
        end
        for (int e = 0; e < 14; e++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (bus.stop === 1'b1) stop_edge = e;
        end
        checks++;
        if (stop_edge != N + 3 || bus.running !== 1'b0) begin
            failures++;
            $display("FAIL stop_latency: got stop at edge %0d running=%b required edge %0d running 0",
                     stop_edge, bus.running, N + 3);
        end
    endtask

    // Both buttons on the same edge: stop wins when running, nothing when idle.
    task automatic test_simultaneous();
        int starts;
        int stops;
        test_reset();
        run_phases("sim_setup", '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{10, 10}, starts, stops);
        run_phases("sim_running", '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{12, 10}, starts, stops);
        checks++;
        if (starts != 0 || stops != 1 || bus.running !== 1'b0) begin
            failures++;
            $display("FAIL sim_running: got starts=%0d stops=%0d running=%b required 0 1 0",
                     starts, stops, bus.running);
        end
        run_phases("sim_idle", '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{12, 10}, starts, stops);
        checks++;
        if (starts != 0 || stops != 0 || bus.running !== 1'b0) begin
            failures++;
            $display("FAIL sim_idle: got starts=%0d stops=%0d running=%b required 0 0 0",
                     starts, stops, bus.running);
        end
    endtask

    // Start while running and stop while idle are both ignored.
    task automatic test_ignored();
        int starts;
        int stops;
        test_reset();
        run_phases("ign_setup", '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{10, 10}, starts, stops);
        run_phases("ign_start", '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{12, 10}, starts, stops);
        checks++;
        if (starts != 0 || stops != 0 || bus.running !== 1'b1) begin
            failures++;
            $display("FAIL ign_start: got starts=%0d stops=%0d running=%b required 0 0 1",
                     starts, stops, bus.running);
        end
        run_phases("ign_to_idle", '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{12, 10}, starts, stops);
        run_phases("ign_stop", '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{12, 10}, starts, stops);
        checks++;
        if (starts != 0 || stops != 0 || bus.running !== 1'b0) begin
            failures++;
            $display("FAIL ign_stop: got starts=%0d stops=%0d running=%b required 0 0 0",
                     starts, stops, bus.running);
        end
    endtask

    // Reset during debounce: progress discarded, held button debounced afresh.
    task automatic test_reset_mid();
        test_reset();
        for (int e = 0; e < 22; e++) begin
            tick(1'b1, 1'b0, (e == 3 || e == 4));
            checks++;
            if (bus.start !== (e == 5 + N + 3) || bus.stop !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid edge %0d: got start=%b stop=%b required %b 0",
                         e, bus.start, bus.stop, (e == 5 + N + 3));
            end
        end
        checks++;
        if (bus.running !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_running: got %b required 1", bus.running);
        end
    endtask

    // Random press lengths around the debounce window, occasional resets.
    task automatic test_random();
        bit lvl [2];
        int rem [2];
        bit rs;
        test_reset();
        for (int b = 0; b < 2; b++) begin
            lvl[b] = 1'b0;
            rem[b] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    rem[b] = int'($urandom_range(1, 3 * N + 4));
                end
                rem[b]--;
            end
            rs = ($urandom_range(0, 299) == 0);
            tick(lvl[0], lvl[1], rs);
            checks++;
            if ({bus.start, bus.stop, bus.running} !== {exp_start, exp_stop, exp_running}) begin
                failures++;
                $display("FAIL random cycle %0d: got %b required %b", c,
                         {bus.start, bus.stop, bus.running}, {exp_start, exp_stop, exp_running});
            end
            checks++;
            if (bus.start === 1'b1 && bus.stop === 1'b1) begin
                failures++;
                $display("FAIL random_exclusive cycle %0d: got start=1 stop=1 required not both", c);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.start_btn = 1'b0;
        bus.stop_btn  = 1'b0;
        test_reset();
        test_latency();
        test_short_press();
        test_start_stop();
        test_simultaneous();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
